// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch path: FSM encoding and PC defaults.
package pc_fetch_ctrl_pkg;

  // Fetch FSM encoding; values are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam int unsigned ADDR_W_DFLT   = 32;
  localparam int unsigned DATA_W_DFLT   = 32;
  // Also used by the address-select and branch logic.
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DFLT   = 32'h0000_0001;

endpackage

// File: rtl/pc_fetch_ctrl_pc_reg.sv
// Program counter register: load-target has priority over increment.
// o_pc_next exposes the value the register takes at the next edge.
module pc_reg
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DFLT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DFLT),
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_INC_DFLT)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_next
);

  logic [ADDR_W-1:0] r_pc;

  // Next PC: redirect target, else sequential (wraps modulo 2^ADDR_W), else hold.
  always_comb begin
    o_pc_next = r_pc;
    if (i_load) begin
      o_pc_next = i_target;
    end else if (i_inc) begin
      o_pc_next = r_pc + PC_INC;
    end
  end

  // PC state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= o_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the PC, issues req/ack fetches to instruction memory
// and hands each fetched word to decode over valid/ready.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DFLT,
  parameter int unsigned       DATA_W   = DATA_W_DFLT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DFLT),
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_INC_DFLT)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_instr_ready,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_target,
  input  logic              i_halt,
  output logic              o_halted
);

  fetch_state_e      r_state, w_state_next;
  logic              r_squash, w_squash_next;
  logic              r_imem_req, w_imem_req_next;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_instr_valid, w_instr_valid_next;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_halted, w_halted_next;

  logic              w_pc_load;
  logic              w_pc_inc;
  logic              w_addr_load;
  logic              w_capture;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_next;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_pc_load),
    .i_target  (i_redirect_target),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc),
    .o_pc_next (w_pc_next)
  );

  // Next-state, PC control and next values of the output registers.
  always_comb begin
    w_state_next       = r_state;
    w_squash_next      = r_squash;
    w_imem_req_next    = r_imem_req;
    w_instr_valid_next = r_instr_valid;
    w_halted_next      = r_halted;
    w_pc_load          = 1'b0;
    w_pc_inc           = 1'b0;
    w_addr_load        = 1'b0;
    w_capture          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_pc_load       = i_redirect_valid;
        w_state_next    = S_REQ;
        w_imem_req_next = 1'b1;
        w_addr_load     = 1'b1;
      end
      S_REQ: begin
        if (i_imem_ack) begin
          w_squash_next = 1'b0;
          if (i_redirect_valid) begin
            // Data is stale the moment it lands; reissue at the target.
            w_pc_load   = 1'b1;
            w_addr_load = 1'b1;
          end else if (r_squash) begin
            // Response belongs to a pre-redirect request; reissue at pc.
            w_addr_load = 1'b1;
          end else begin
            w_capture          = 1'b1;
            w_pc_inc           = 1'b1;
            w_instr_valid_next = 1'b1;
            w_imem_req_next    = 1'b0;
            w_state_next       = S_HOLD;
          end
        end else if (i_redirect_valid) begin
          // Outstanding request must finish at its original address.
          w_pc_load     = 1'b1;
          w_squash_next = 1'b1;
        end
      end
      S_HOLD: begin
        w_pc_load = i_redirect_valid;
        if (i_instr_ready) begin
          w_instr_valid_next = 1'b0;
          if (i_halt) begin
            w_state_next  = S_HALT;
            w_halted_next = 1'b1;
          end else begin
            w_state_next    = S_REQ;
            w_imem_req_next = 1'b1;
            w_addr_load     = 1'b1;
          end
        end
      end
      S_HALT: begin
        w_imem_req_next    = 1'b0;
        w_instr_valid_next = 1'b0;
        w_halted_next      = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state and control flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_squash      <= 1'b0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_squash      <= w_squash_next;
      r_imem_req    <= w_imem_req_next;
      r_instr_valid <= w_instr_valid_next;
      r_halted      <= w_halted_next;
    end
  end

  // Fetch address: latched from the next PC only when a request is issued,
  // so a redirect never disturbs an outstanding request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_imem_addr <= RESET_PC;
    end else if (w_addr_load) begin
      r_imem_addr <= w_pc_next;
    end
  end

  // Instruction word and its address, captured on an accepted response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= i_imem_rdata;
      r_instr_pc <= r_imem_addr;
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr_valid = r_instr_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_halted      = r_halted;

endmodule
